// File: rtl/rgb_fade_wbm32.sv
`default_nettype none
// ============================================================================
// Module      : rgb_fade_wbm32
// Description : Fades an RGB colour toward a commanded target one LSB per
//               channel per step, writing every intermediate colour to an
//               RGB PWM slave through a Wishbone classic master port.
//               Writes that receive no ack are abandoned after 256 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_fade_wbm32 #(
  parameter logic [31:0] TARGET_ADR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_rgb,
  input  logic [15:0] cmd_period,
  output logic        busy,
  output logic        err,
  output logic [23:0] cur_rgb,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    WRITE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // Last WRITE cycle index before the write is abandoned (256 cycles total).
  localparam logic [7:0] TMO_LAST = 8'd255;

  state_t      state;
  state_t      state_nx;
  logic [23:0] target;
  logic [23:0] target_nx;
  logic [23:0] cur_nx;
  logic [15:0] period;
  logic [15:0] period_nx;
  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_nx;
  logic [7:0]  tmo_cnt;
  logic [7:0]  tmo_cnt_nx;
  logic        err_nx;

  // Move one channel a single LSB toward its target; saturating by
  // construction because it never moves past an equal value.
  function automatic logic [7:0] step_chan(input logic [7:0] cur,
                                           input logic [7:0] tgt);
    logic [7:0] res;
    res = cur;
    if (cur < tgt) begin
      res = cur + 8'd1;
    end else if (cur > tgt) begin
      res = cur - 8'd1;
    end
    return res;
  endfunction

  // Next-state logic and the values that will be loaded into the registers.
  always_comb begin
    state_nx    = state;
    target_nx   = target;
    period_nx   = period;
    cur_nx      = cur_rgb;
    wait_cnt_nx = wait_cnt;
    tmo_cnt_nx  = tmo_cnt;
    err_nx      = 1'b0;
    case (state)
      IDLE: begin
        // cmd_ready is low for the first cycle after reset, so gate on it
        // rather than on the state alone.
        if (cmd_valid && cmd_ready) begin
          target_nx = cmd_rgb;
          period_nx = (cmd_period == 16'd0) ? 16'd1 : cmd_period;
          state_nx  = STEP;
        end
      end
      STEP: begin
        cur_nx     = {step_chan(cur_rgb[23:16], target[23:16]),
                      step_chan(cur_rgb[15:8],  target[15:8]),
                      step_chan(cur_rgb[7:0],   target[7:0])};
        tmo_cnt_nx = 8'd0;
        state_nx   = WRITE;
      end
      WRITE: begin
        if (wbm_ack_i) begin
          if (cur_rgb == target) begin
            state_nx = IDLE;
          end else begin
            wait_cnt_nx = period;
            state_nx    = WAIT;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          tmo_cnt_nx = tmo_cnt + 8'd1;
        end
      end
      WAIT: begin
        // period is never zero, so a count of one ends the wait.
        if (wait_cnt <= 16'd1) begin
          state_nx = STEP;
        end else begin
          wait_cnt_nx = wait_cnt - 16'd1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      target    <= 24'd0;
      period    <= 16'd0;
      cur_rgb   <= 24'd0;
      wait_cnt  <= 16'd0;
      tmo_cnt   <= 8'd0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'd0;
      wbm_adr_o <= 32'd0;
      wbm_dat_o <= 32'd0;
    end else begin
      state     <= state_nx;
      target    <= target_nx;
      period    <= period_nx;
      cur_rgb   <= cur_nx;
      wait_cnt  <= wait_cnt_nx;
      tmo_cnt   <= tmo_cnt_nx;
      cmd_ready <= (state_nx == IDLE);
      busy      <= (state_nx != IDLE);
      err       <= err_nx;
      wbm_cyc_o <= (state_nx == WRITE);
      wbm_stb_o <= (state_nx == WRITE);
      wbm_we_o  <= (state_nx == WRITE);
      wbm_sel_o <= (state_nx == WRITE) ? 4'b0111 : 4'd0;
      wbm_adr_o <= (state_nx == WRITE) ? TARGET_ADR : 32'd0;
      wbm_dat_o <= (state_nx == WRITE) ? {8'h00, cur_nx} : 32'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rgb_fade_wbm32.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb_fade_wbm32
// Description : Directed self-checking bench for rgb_fade_wbm32 with a
//               single-cycle-ack Wishbone slave and a write recorder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_fade_wbm32;

  localparam logic [31:0] ADR = 32'h1000_0040;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_rgb;
  logic [15:0] cmd_period;
  logic        busy;
  logic        err;
  logic [23:0] cur_rgb;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;

  logic        ack_en;
  logic        slave_ack;
  logic        late_ack;

  int vectors;
  int miscompares;
  int cyc_n;
  logic timed_out;

  logic [31:0] wr_dat[$];
  logic [3:0]  wr_sel[$];
  logic [31:0] wr_adr[$];
  int          wr_cyc[$];

  assign wbm_ack_i = slave_ack | late_ack;

  rgb_fade_wbm32 #(.TARGET_ADR(ADR)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rgb   (cmd_rgb),
    .cmd_period(cmd_period),
    .busy      (busy),
    .err       (err),
    .cur_rgb   (cur_rgb),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to time the gaps between writes.
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Slave: acknowledges each strobe for exactly one cycle.
  always @(posedge clk) slave_ack <= ack_en && wbm_cyc_o && wbm_stb_o && !slave_ack;

  // Recorder: logs every completed write cycle.
  always @(posedge clk) begin
    if (!rst && wbm_cyc_o && wbm_stb_o && wbm_we_o && wbm_ack_i) begin
      wr_dat.push_back(wbm_dat_o);
      wr_sel.push_back(wbm_sel_o);
      wr_adr.push_back(wbm_adr_o);
      wr_cyc.push_back(cyc_n);
    end
  end

  task automatic clear_log();
    wr_dat.delete();
    wr_sel.delete();
    wr_adr.delete();
    wr_cyc.delete();
  endtask

  task automatic send_cmd(input logic [23:0] rgb, input logic [15:0] per);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_rgb    = rgb;
    cmd_period = per;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    timed_out = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!busy && cmd_ready) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cmd_ready, busy, err, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 6'b0) begin
      $display("FAIL reset_ctrl: got %b want 000000",
               {cmd_ready, busy, err, wbm_cyc_o, wbm_stb_o, wbm_we_o});
      miscompares++;
    end
    vectors++;
    if ({cur_rgb, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== 92'd0) begin
      $display("FAIL reset_data: cur=%h sel=%h adr=%h dat=%h want all 0",
               cur_rgb, wbm_sel_o, wbm_adr_o, wbm_dat_o);
      miscompares++;
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
      miscompares++;
    end
  endtask

  task automatic test_basic_fade();
    clear_log();
    send_cmd(24'h000003, 16'd2);
    wait_idle(200);
    vectors++;
    if (timed_out || wr_dat.size() != 3) begin
      $display("FAIL basic_count: got %0d writes (timeout=%b) want 3", wr_dat.size(), timed_out);
      miscompares++;
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (wr_dat[i] !== 32'(i + 1) || wr_sel[i] !== 4'b0111 || wr_adr[i] !== ADR) begin
          $display("FAIL basic_write%0d: dat=%h sel=%b adr=%h want dat=%h sel=0111 adr=%h",
                   i, wr_dat[i], wr_sel[i], wr_adr[i], i + 1, ADR);
          miscompares++;
        end
      end
      vectors++;
      if (wr_cyc[1] - wr_cyc[0] != 5) begin
        $display("FAIL basic_gap: got %0d cycles want 5", wr_cyc[1] - wr_cyc[0]);
        miscompares++;
      end
    end
    vectors++;
    if (busy !== 1'b0 || cur_rgb !== 24'h000003) begin
      $display("FAIL basic_end: busy=%b cur=%h want busy=0 cur=000003", busy, cur_rgb);
      miscompares++;
    end
    vectors++;
    if ({wbm_sel_o, wbm_adr_o, wbm_dat_o} !== 68'd0) begin
      $display("FAIL basic_idle_bus: sel=%h adr=%h dat=%h want 0", wbm_sel_o, wbm_adr_o, wbm_dat_o);
      miscompares++;
    end
  endtask

  task automatic test_equal_target();
    clear_log();
    send_cmd(24'h000003, 16'd5);
    wait_idle(100);
    vectors++;
    if (timed_out || wr_dat.size() != 1 || wr_dat[0] !== 32'h0000_0003) begin
      $display("FAIL equal_write: got %0d writes first=%h want 1 write of 00000003",
               wr_dat.size(), (wr_dat.size() > 0) ? wr_dat[0] : 32'hx);
      miscompares++;
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL equal_ready: got %b want 1", cmd_ready);
      miscompares++;
    end
  endtask

  task automatic test_full_fade();
    logic bad;
    clear_log();
    send_cmd(24'h0000FF, 16'd0);
    wait_idle(2000);
    vectors++;
    if (timed_out || wr_dat.size() != 252 || cur_rgb !== 24'h0000FF) begin
      $display("FAIL full_up: got %0d writes cur=%h want 252 writes cur=0000ff", wr_dat.size(), cur_rgb);
      miscompares++;
    end
    clear_log();
    send_cmd(24'hFF0000, 16'd0);
    wait_idle(3000);
    vectors++;
    if (timed_out || wr_dat.size() != 255) begin
      $display("FAIL full_count: got %0d writes want 255", wr_dat.size());
      miscompares++;
    end else begin
      bad = 1'b0;
      for (int i = 0; i < 255; i++) begin
        if (wr_dat[i] !== {8'h00, 8'(i + 1), 8'h00, 8'(254 - i)}) bad = 1'b1;
      end
      vectors++;
      if (bad) begin
        $display("FAIL full_sequence: first=%h last=%h want 00010000fe..00ff0000", wr_dat[0], wr_dat[254]);
        miscompares++;
      end
      vectors++;
      if (wr_dat[254] !== 32'h00FF_0000) begin
        $display("FAIL full_final: got %h want 00ff0000", wr_dat[254]);
        miscompares++;
      end
      vectors++;
      if (wr_cyc[1] - wr_cyc[0] != 4) begin
        $display("FAIL full_gap: got %0d cycles want 4", wr_cyc[1] - wr_cyc[0]);
        miscompares++;
      end
    end
  endtask

  task automatic test_timeout();
    int cyc_cnt;
    int err_cnt;
    logic [31:0] dat_seen;
    clear_log();
    ack_en   = 1'b0;
    cyc_cnt  = 0;
    err_cnt  = 0;
    dat_seen = 32'd0;
    send_cmd(24'hFF0001, 16'd1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wbm_cyc_o) begin
        if (cyc_cnt == 0) dat_seen = wbm_dat_o;
        cyc_cnt++;
      end
      if (err) err_cnt++;
    end
    vectors++;
    if (cyc_cnt != 256) begin
      $display("FAIL timeout_cyc: got %0d cycles want 256", cyc_cnt);
      miscompares++;
    end
    vectors++;
    if (err_cnt != 1) begin
      $display("FAIL timeout_err: got %0d pulses want 1", err_cnt);
      miscompares++;
    end
    vectors++;
    if (dat_seen !== 32'h00FF_0001 || cur_rgb !== 24'hFF0001) begin
      $display("FAIL timeout_cur: dat=%h cur=%h want dat=00ff0001 cur=ff0001", dat_seen, cur_rgb);
      miscompares++;
    end
    vectors++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || wr_dat.size() != 0) begin
      $display("FAIL timeout_idle: busy=%b ready=%b writes=%0d want 0 1 0", busy, cmd_ready, wr_dat.size());
      miscompares++;
    end
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    logic seen;
    clear_log();
    ack_en = 1'b0;
    seen   = 1'b0;
    send_cmd(24'h000000, 16'd1);
    for (int i = 0; i < 10; i++) begin
      if (wbm_cyc_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (!seen || wbm_dat_o !== 32'h00FE_0000) begin
      $display("FAIL rstmid_write: cyc_seen=%b dat=%h want 1 00fe0000", seen, wbm_dat_o);
      miscompares++;
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || cur_rgb !== 24'd0 || busy !== 1'b0) begin
      $display("FAIL rstmid_drop: cyc=%b stb=%b cur=%h busy=%b want 0 0 000000 0",
               wbm_cyc_o, wbm_stb_o, cur_rgb, busy);
      miscompares++;
    end
    rst      = 1'b0;
    late_ack = 1'b1;
    repeat (3) @(negedge clk);
    late_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (wr_dat.size() != 0 || busy !== 1'b0 || cmd_ready !== 1'b1 || cur_rgb !== 24'd0) begin
      $display("FAIL rstmid_late_ack: writes=%0d busy=%b ready=%b cur=%h want 0 0 1 000000",
               wr_dat.size(), busy, cmd_ready, cur_rgb);
      miscompares++;
    end
    ack_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_dat[6];
    int writes_at_ready;
    logic found;
    exp_dat = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd3, 32'd2};
    clear_log();
    found = 1'b0;
    writes_at_ready = -1;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_rgb    = 24'h000004;
    cmd_period = 16'd3;
    @(negedge clk);
    cmd_rgb    = 24'h000002;
    cmd_period = 16'd1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        found = 1'b1;
        writes_at_ready = wr_dat.size();
        break;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if (!found || writes_at_ready != 4) begin
      $display("FAIL b2b_first_idle: ready_seen=%b writes_before=%0d want 1 4", found, writes_at_ready);
      miscompares++;
    end
    wait_idle(200);
    vectors++;
    if (timed_out || wr_dat.size() != 6) begin
      $display("FAIL b2b_count: got %0d writes want 6", wr_dat.size());
      miscompares++;
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (wr_dat[i] !== exp_dat[i]) begin
          $display("FAIL b2b_write%0d: got %h want %h", i, wr_dat[i], exp_dat[i]);
          miscompares++;
        end
      end
      vectors++;
      if (wr_cyc[1] - wr_cyc[0] != 6 || wr_cyc[4] - wr_cyc[3] != 4 || wr_cyc[5] - wr_cyc[4] != 4) begin
        $display("FAIL b2b_gaps: got %0d %0d %0d want 6 4 4",
                 wr_cyc[1] - wr_cyc[0], wr_cyc[4] - wr_cyc[3], wr_cyc[5] - wr_cyc[4]);
        miscompares++;
      end
    end
  endtask

  // Scenario sequence; each test leaves the DUT idle for the next one.
  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc_n       = 0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_rgb     = 24'd0;
    cmd_period  = 16'd0;
    ack_en      = 1'b1;
    slave_ack   = 1'b0;
    late_ack    = 1'b0;
    timed_out   = 1'b0;
    test_reset();
    test_basic_fade();
    test_equal_target();
    test_full_fade();
    test_timeout();
    test_reset_mid_write();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgb_fade_wbm32.md
RGB_FADE_WBM32 -- requirements
Module: rgb_fade_wbm32

Interface
REQ-001 The block SHALL have one parameter, TARGET_ADR: default 32'h0000_0000; the Wishbone address of the RGB PWM slave's colour register.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL provide the following ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  fade command present.
- cmd_ready  out  1  block accepts command.
- cmd_rgb  in  24  target colour {B[23:16],G[15:8],R[7:0]}.
- cmd_period  in  16  clocks spent in WAIT between steps.
- busy  out  1  fade in progress.
- err  out  1  one-cycle pulse on write timeout.
- cur_rgb  out  24  colour last driven.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte selects.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_ack_i  in  1  slave acknowledge.

Function
REQ-004 The block SHALL implement states IDLE, STEP, WRITE and WAIT; state and all outputs SHALL be registered.
REQ-005 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a clock edge with cmd_valid=1 and cmd_ready=1.
REQ-006 On acceptance the block SHALL latch cmd_rgb as target and max(cmd_period,1) as period, then go to STEP.
REQ-007 cmd_valid outside IDLE SHALL be ignored, with no latching.
REQ-008 STEP SHALL last one cycle and then go to WRITE. In that cycle each 8-bit channel of cur_rgb SHALL move 1 toward its target channel, or hold if equal. There SHALL be no wrap (255 never goes to 0).
REQ-009 While in WRITE, the block SHALL drive the following; all SHALL be stable until ack:
- wbm_cyc_o=wbm_stb_o=wbm_we_o=1.
- wbm_sel_o=4'b0111.
- wbm_adr_o=TARGET_ADR.
- wbm_dat_o={8'h00,cur_rgb}.
REQ-010 In WRITE, on an edge with wbm_ack_i=1, the block SHALL drop cyc/stb/we on the next cycle and go to IDLE if cur_rgb==target, else to WAIT.
REQ-011 WAIT SHALL last exactly period cycles and then go to STEP.
REQ-012 A command whose target equals cur_rgb SHALL still perform exactly one write and then return to IDLE.
REQ-013 Timeout: if wbm_ack_i is not seen within 256 cycles of entering WRITE, the block SHALL perform all of the following:
- drop cyc/stb.
- pulse err for 1 cycle.
- go to IDLE.
- retain cur_rgb.
REQ-014 wbm_ack_i outside WRITE SHALL be ignored.
REQ-015 busy SHALL equal (state!=IDLE).
REQ-016 wbm_sel_o, wbm_adr_o and wbm_dat_o SHALL be 0 outside WRITE.
REQ-017 A fade SHALL take at most 255 steps, i.e. the largest channel distance.

Reset
REQ-018 While rst=1 the block SHALL hold the following:
- state=IDLE.
- cur_rgb=0 and target=0.
- wbm_cyc_o=wbm_stb_o=wbm_we_o=0.
- wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0.
- err=0, busy=0, cmd_ready=0.
REQ-019 cmd_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-020 When rst is asserted mid-WRITE, the block SHALL deassert cyc/stb in the cycle after the reset edge, and any ack arriving afterwards SHALL be ignored.

Verification
REQ-021 Single-cycle-ack slave, cmd_rgb=24'h000003, period=2, from reset → exactly 3 writes with dat=0x00000001, 0x00000002, 0x00000003; then IDLE, busy=0.
REQ-022 Start at cur=24'h0000FF, cmd_rgb=24'hFF0000, period=0 (treated as 1) → 255 writes; final dat=0x00FF0000; no channel wraps.
REQ-023 cmd_rgb equal to cur_rgb → exactly one write, then cmd_ready=1.
REQ-024 Slave withholding ack → cyc high for exactly 256 cycles, err pulses once, cur_rgb unchanged, state IDLE.
REQ-025 rst asserted while cyc=1 → cyc=0 one cycle later, cur_rgb=0, a late ack causes no write.
REQ-026 cmd_valid held high throughout a fade with a different cmd_rgb → the new command is accepted only on the first IDLE cycle.
